// File: rtl/mips_ctrl_pkg.sv
// Shared opcode map, ALU operation encodings and the control-word layout for the main decoder.
package mips_ctrl_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_SLT  = 4'd4;
  localparam logic [3:0] OP_ADDI = 4'd5;
  localparam logic [3:0] OP_ST   = 4'd6;
  localparam logic [3:0] OP_LD   = 4'd7;
  localparam logic [3:0] OP_BEQ  = 4'd8;
  localparam logic [3:0] OP_J    = 4'd9;
  localparam logic [3:0] OP_ORI  = 4'd10;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;

  typedef struct packed {
    logic       reg_wr;
    logic       reg_des;
    logic       alu_src;
    logic       mem2reg;
    logic       mem_r;
    logic       mem_w;
    logic       branch;
    logic       jump;
    logic [2:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational opcode-to-control-word decode; zero latency, no flow control.
// Anything outside the map (including X in four-state simulation) falls to the safe NOP word with illegal set.
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
#(
  parameter int OPW = 4
) (
  input  logic [OPW-1:0] i_opcode,
  output ctrl_t          o_ctrl,
  output logic           o_illegal
);

  always_comb begin
    o_ctrl    = '0;
    o_illegal = 1'b0;
    case (i_opcode)
      OP_ADD:  begin o_ctrl.reg_wr = 1'b1; o_ctrl.reg_des = 1'b1; o_ctrl.alu_op = ALU_ADD; end
      OP_SUB:  begin o_ctrl.reg_wr = 1'b1; o_ctrl.reg_des = 1'b1; o_ctrl.alu_op = ALU_SUB; end
      OP_AND:  begin o_ctrl.reg_wr = 1'b1; o_ctrl.reg_des = 1'b1; o_ctrl.alu_op = ALU_AND; end
      OP_OR:   begin o_ctrl.reg_wr = 1'b1; o_ctrl.reg_des = 1'b1; o_ctrl.alu_op = ALU_OR;  end
      OP_SLT:  begin o_ctrl.reg_wr = 1'b1; o_ctrl.reg_des = 1'b1; o_ctrl.alu_op = ALU_SLT; end
      OP_ADDI: begin o_ctrl.reg_wr = 1'b1; o_ctrl.alu_src = 1'b1; end
      OP_ST:   begin o_ctrl.alu_src = 1'b1; o_ctrl.mem_w = 1'b1; end
      OP_LD: begin
        o_ctrl.reg_wr  = 1'b1;
        o_ctrl.alu_src = 1'b1;
        o_ctrl.mem2reg = 1'b1;
        o_ctrl.mem_r   = 1'b1;
      end
      OP_BEQ:  begin o_ctrl.branch = 1'b1; o_ctrl.alu_op = ALU_SUB; end
      OP_J:    o_ctrl.jump = 1'b1;
      OP_ORI:  begin o_ctrl.reg_wr = 1'b1; o_ctrl.alu_src = 1'b1; o_ctrl.alu_op = ALU_OR; end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_ctrl_unit.sv
// Main control decoder: opcode sampled each rising clk, strobes valid one cycle later; no handshake.
// Outputs reset asynchronously to the all-zero NOP word.
module mips_ctrl_unit
  import mips_ctrl_pkg::*;
#(
  parameter int OPW = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [OPW-1:0] Opcode,
  output logic           RegWr,
  output logic           RegDes,
  output logic           AluSrc,
  output logic           Mem2Reg,
  output logic           MemR,
  output logic           MemW,
  output logic           Branch,
  output logic           Jump,
  output logic [2:0]     AluOp,
  output logic           Illegal
);

  ctrl_t w_ctrl;
  logic  w_illegal;
  ctrl_t r_ctrl;
  logic  r_illegal;

  mips_ctrl_decode #(.OPW(OPW)) u_decode (
    .i_opcode  (Opcode),
    .o_ctrl    (w_ctrl),
    .o_illegal (w_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl    <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_ctrl    <= w_ctrl;
      r_illegal <= w_illegal;
    end
  end

  assign RegWr   = r_ctrl.reg_wr;
  assign RegDes  = r_ctrl.reg_des;
  assign AluSrc  = r_ctrl.alu_src;
  assign Mem2Reg = r_ctrl.mem2reg;
  assign MemR    = r_ctrl.mem_r;
  assign MemW    = r_ctrl.mem_w;
  assign Branch  = r_ctrl.branch;
  assign Jump    = r_ctrl.jump;
  assign AluOp   = r_ctrl.alu_op;
  assign Illegal = r_illegal;

endmodule

// File: tb/tb_mips_ctrl_unit.sv
// Directed and randomized checks of the control decoder against a rule-based reference model.
module tb_mips_ctrl_unit;

  logic       clk;
  logic       rst_n;
  logic [3:0] Opcode;
  logic       RegWr, RegDes, AluSrc, Mem2Reg, MemR, MemW, Branch, Jump, Illegal;
  logic [2:0] AluOp;

  int tests;
  int fails;

  mips_ctrl_unit #(.OPW(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .Opcode  (Opcode),
    .RegWr   (RegWr),
    .RegDes  (RegDes),
    .AluSrc  (AluSrc),
    .Mem2Reg (Mem2Reg),
    .MemR    (MemR),
    .MemW    (MemW),
    .Branch  (Branch),
    .Jump    (Jump),
    .AluOp   (AluOp),
    .Illegal (Illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {RegWr,RegDes,AluSrc,Mem2Reg,MemR,MemW,Branch,Jump,AluOp[2:0],Illegal}
  function automatic logic [11:0] model(input logic [3:0] op);
    logic       rtype, load, store, imm_alu, ill;
    logic [2:0] aop;
    ill     = $isunknown(op) || (op > 4'd10);
    rtype   = !ill && (op <= 4'd4);
    load    = !ill && (op == 4'd7);
    store   = !ill && (op == 4'd6);
    imm_alu = !ill && (op == 4'd5 || op == 4'd10);
    if (rtype)                   aop = op[2:0];
    else if (!ill && op == 4'd8) aop = 3'd1;
    else if (!ill && op == 4'd10) aop = 3'd3;
    else                         aop = 3'd0;
    return {rtype || load || imm_alu, rtype, load || store || imm_alu, load, load, store,
            !ill && op == 4'd8, !ill && op == 4'd9, aop, ill};
  endfunction

  function automatic logic [11:0] observed();
    return {RegWr, RegDes, AluSrc, Mem2Reg, MemR, MemW, Branch, Jump, AluOp, Illegal};
  endfunction

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_inv(input string tag);
    logic ok;
    ok = !(MemR && MemW) && !(Branch && Jump) && !(MemW && RegWr) && !(Mem2Reg && !MemR);
    check(tag, {11'd0, ok}, 12'd1);
  endtask

  // Apply op just after an edge, then check one edge later.
  task automatic step(input string tag, input logic [3:0] op);
    Opcode = op;
    @(posedge clk);
    #1;
    check(tag, observed(), model(op));
  endtask

  initial begin
    tests  = 0;
    fails  = 0;
    rst_n  = 1'b0;
    Opcode = 4'd7;
    #1;
    check("reset_initial", observed(), 12'd0);
    @(posedge clk);
    #1;
    check("reset_held_over_edge", observed(), 12'd0);

    rst_n = 1'b1;
    step("ld_before_reset", 4'd7);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_midcycle", observed(), 12'd0);
    #1 rst_n = 1'b1;
    #1;
    check("reset_release_holds_zero", observed(), 12'd0);
    @(posedge clk);
    #1;
    check("ld_after_release", observed(), 12'b1011_1000_0000);

    for (int op = 0; op <= 10; op++)
      step($sformatf("sweep_op%0d", op), 4'(op));

    step("st_vector", 4'd6);
    check("st_const", observed(), 12'b0010_0100_0000);
    step("beq_vector", 4'd8);
    check("beq_const", observed(), 12'b0000_0010_0010);
    step("j_vector", 4'd9);
    check("j_const", observed(), 12'b0000_0001_0000);
    step("sub_rtype", 4'd1);
    check("sub_const", observed(), 12'b1100_0000_0010);

    for (int op = 11; op <= 15; op++) begin
      step($sformatf("illegal_op%0d", op), 4'(op));
      check($sformatf("illegal_const%0d", op), observed(), 12'b0000_0000_0001);
    end

    // Under a two-state simulator the X collapses to a real value; the model follows what was driven.
    Opcode = 4'bx;
    @(posedge clk);
    #1;
    check("x_opcode", observed(), model(Opcode));

    for (int cyc = 0; cyc < 1000; cyc++) begin
      step("rand_vector", 4'($urandom_range(0, 15)));
      check_inv("rand_invariants");
      if ($urandom_range(0, 49) == 0) begin
        #2 rst_n = 1'b0;
        #1;
        check("rand_reset_zero", observed(), 12'd0);
        #1 rst_n = 1'b1;
        #1;
        check("rand_reset_released_zero", observed(), 12'd0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mips_ctrl_unit.md
Name: mips_ctrl_unit

Overview:
Main control decoder for the phase-1 4-bit-opcode MIPS-style CPU. It maps the instruction opcode to the datapath control strobes: register write, destination select, ALU source, memory read/write, write-back mux, branch and jump. It sits between instruction decode and the datapath. Outputs are registered and reset asynchronously to a safe all-zero (NOP) state.

Parameters:
OPW, 4, opcode width (fixed; the decode map below assumes 4)

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
Opcode  input  4  instruction opcode
RegWr  output  1  register file write enable
RegDes  output  1  destination register select: 1 = rd (R-type), 0 = rt (I-type)
AluSrc  output  1  ALU B operand: 1 = sign-extended immediate, 0 = register
Mem2Reg  output  1  write-back select: 1 = data memory, 0 = ALU result
MemR  output  1  data memory read enable
MemW  output  1  data memory write enable
Branch  output  1  conditional branch (beq)
Jump  output  1  unconditional jump
AluOp  output  3  ALU operation: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT
Illegal  output  1  opcode not in map (11..15)

Behaviour:
- Reset: while rst_n=0, all outputs are 0, asynchronously. Deassertion takes effect at the next rising clk.
- Latency: one cycle. Opcode is sampled on each rising clk. Outputs reflect that sample until the next edge. There is no handshake; the block decodes every cycle.
- Decode map. Signals not listed are 0. Order is RegWr, RegDes, AluSrc, Mem2Reg, MemR, MemW, Branch, Jump, AluOp.
- 0 ADD: 1,1,0,0,0,0,0,0, ADD
- 1 SUB: 1,1,0,0,0,0,0,0, SUB
- 2 AND: 1,1,0,0,0,0,0,0, AND
- 3 OR: 1,1,0,0,0,0,0,0, OR
- 4 SLT: 1,1,0,0,0,0,0,0, SLT
- 5 ADDI: 1,0,1,0,0,0,0,0, ADD
- 6 ST: 0,0,1,0,0,1,0,0, ADD (address calculation)
- 7 LD: 1,0,1,1,1,0,0,0, ADD
- 8 BEQ: 0,0,0,0,0,0,1,0, SUB
- 9 J: 0,0,0,0,0,0,0,1, ADD
- 10 ORI: 1,0,1,0,0,0,0,0, OR
- 11..15: all strobes 0, AluOp=ADD, Illegal=1.
- Illegal is 0 for opcodes 0..10.
- Invariants, true every cycle: MemR and MemW are never both 1. Branch and Jump are never both 1. MemW=1 implies RegWr=0. Mem2Reg=1 implies MemR=1.
- Unknown or X Opcode is treated as illegal: all-zero strobes and Illegal=1. No X propagates to the strobes.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - opcode localparams OP_ADD..OP_ORI (0..10)
  - AluOp encodings ALU_ADD..ALU_SLT
  - a packed control-word typedef bundling the strobes and AluOp
- Sub-module mips_ctrl_decode: purely combinational case decode from Opcode to the control word plus Illegal.
- Top level: instantiates mips_ctrl_decode and registers its outputs with the async active-low reset.

Test Plan:
- Reset: rst_n=0 mid-cycle with Opcode=7 -> all outputs 0 immediately. Release rst_n, then Opcode=7 at the next edge -> RegWr=1, AluSrc=1, Mem2Reg=1, MemR=1, others 0.
- Sweep Opcode 0..10, one per clock -> each output vector matches the map exactly, one cycle after apply. R-type 0..4: RegWr=1, RegDes=1, AluOp 0..4.
- Opcode=6 (ST) -> MemW=1, AluSrc=1, RegWr=0, MemR=0, AluOp=0.
- Opcode=8 -> Branch=1, AluOp=1, all else 0. Opcode=9 -> Jump=1 only.
- Opcodes 11..15 and 4'bx -> Illegal=1, all strobes 0.
- Random opcodes for 1000 cycles with asynchronous reset pulses -> invariants hold every cycle; outputs are all zero during reset.
